// File: rtl/irq_encoder16_4.sv
// rtl/irq_encoder16_4.sv - sequential 16:4 priority encoder with pending latch, mask and ack handshake
//
// Purpose:
//   Collects 16 level request lines and turns each rising edge into a pending
//   bit. Presents the highest-numbered pending, unmasked source as a 4-bit
//   index with valid. The index is held frozen until the consumer acks it.
//
// Ports:
//   clk      in   1   system clock, rising edge
//   reset    in   1   asynchronous, active-high reset
//   req      in  16   level request lines (0->1 edge makes a source pending)
//   mask_we  in   1   load mask_in into the mask register
//   mask_in  in  16   new mask, bit = 1 enables the source for selection
//   ack      in   1   consumer accepts idx (only honoured while valid = 1)
//   valid    out  1   idx holds a stable, presented source number
//   idx      out  4   presented source number (holds last value when valid = 0)
//   pending  out 16   pending register, unmasked view

module irq_encoder16_4 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] req,
  input  logic        mask_we,
  input  logic [15:0] mask_in,
  input  logic        ack,
  output logic        valid,
  output logic [3:0]  idx,
  output logic [15:0] pending
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  state_t      state_q;
  logic [15:0] req_q;
  logic [15:0] pending_q;
  logic [15:0] pending_d;
  logic [15:0] mask_q;
  logic [15:0] mask_d;
  logic        valid_q;
  logic [3:0]  idx_q;

  logic [15:0] rise;
  logic [15:0] clr_vec;
  logic [15:0] eligible;
  logic [3:0]  win_idx;

  // Highest set bit wins; scanning upward lets later (higher) bits override.
  function automatic logic [3:0] pick_highest(input logic [15:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) r = i[3:0];
    end
    return r;
  endfunction

  always_comb begin
    rise     = req & ~req_q;
    // Selection looks at registered state only, so a mask load on the same
    // edge as the IDLE->PRESENT decision is seen one cycle later.
    eligible = pending_q & mask_q;
    win_idx  = pick_highest(eligible);

    clr_vec = 16'h0000;
    if (state_q == ST_PRESENT && ack) begin
      clr_vec = 16'h0001 << idx_q;
    end

    // Set after clear: a new rise on the acked bit keeps it pending.
    pending_d = (pending_q & ~clr_vec) | rise;

    mask_d = mask_q;
    if (mask_we) begin
      mask_d = mask_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q     <= 16'h0000;
      pending_q <= 16'h0000;
      mask_q    <= 16'hFFFF;
    end else begin
      req_q     <= req;
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  end

  // Presentation FSM with registered valid/idx outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      idx_q   <= 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (eligible != 16'h0000) begin
            idx_q   <= win_idx;
            valid_q <= 1'b1;
            state_q <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          // idx stays frozen regardless of mask or pending changes.
          if (ack) begin
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign valid   = valid_q;
  assign idx     = idx_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_irq_encoder16_4.sv
// tb/tb_irq_encoder16_4.sv - directed self-checking bench for irq_encoder16_4

module tb_irq_encoder16_4;

  logic        clk;
  logic        reset;
  logic [15:0] req;
  logic        mask_we;
  logic [15:0] mask_in;
  logic        ack;
  logic        valid;
  logic [3:0]  idx;
  logic [15:0] pending;

  int total_cnt;
  int bad_cnt;

  irq_encoder16_4 dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .mask_we (mask_we),
    .mask_in (mask_in),
    .ack     (ack),
    .valid   (valid),
    .idx     (idx),
    .pending (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs changed after this are seen at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle request pulse, sampled at the next edge.
  task automatic pulse(input logic [15:0] v);
    req = v;
    tick();
    req = 16'h0000;
  endtask

  task automatic load_mask(input logic [15:0] m);
    mask_we = 1'b1;
    mask_in = m;
    tick();
    mask_we = 1'b0;
  endtask

  // Ack the current presentation for one edge and check valid dropped.
  task automatic do_ack(input string tag, input logic [15:0] exp_pend);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check({tag, "_valid_low"}, {31'd0, valid}, 32'd0);
    check({tag, "_pend"}, {16'd0, pending}, {16'd0, exp_pend});
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    reset     = 1'b1;
    req       = 16'h0000;
    mask_we   = 1'b0;
    mask_in   = 16'h0000;
    ack       = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_idx", {28'd0, idx}, 32'd0);
    check("rst_pend", {16'd0, pending}, 32'h0000);

    // Single source, two-edge latency
    pulse(16'h0020);
    check("s5_pend", {16'd0, pending}, 32'h0020);
    check("s5_valid_early", {31'd0, valid}, 32'd0);
    tick();
    check("s5_valid", {31'd0, valid}, 32'd1);
    check("s5_idx", {28'd0, idx}, 32'd5);
    do_ack("s5_ack", 16'h0000);

    // Priority ordering 12, 3, 0
    pulse(16'h1009);
    check("pri_pend", {16'd0, pending}, 32'h1009);
    tick();
    check("pri12_valid", {31'd0, valid}, 32'd1);
    check("pri12_idx", {28'd0, idx}, 32'd12);
    do_ack("pri12_ack", 16'h0009);
    tick();
    check("pri3_valid", {31'd0, valid}, 32'd1);
    check("pri3_idx", {28'd0, idx}, 32'd3);
    do_ack("pri3_ack", 16'h0001);
    tick();
    check("pri0_valid", {31'd0, valid}, 32'd1);
    check("pri0_idx", {28'd0, idx}, 32'd0);
    do_ack("pri0_ack", 16'h0000);

    // Mask 7FFF: only 2 selected, 15 stays pending
    load_mask(16'h7FFF);
    pulse(16'h8004);
    check("msk_pend", {16'd0, pending}, 32'h8004);
    tick();
    check("msk2_valid", {31'd0, valid}, 32'd1);
    check("msk2_idx", {28'd0, idx}, 32'd2);
    do_ack("msk2_ack", 16'h8000);
    tick();
    check("msk15_blocked", {31'd0, valid}, 32'd0);
    // Mask load on the decision edge: old mask still blocks 15
    load_mask(16'hFFFF);
    check("msk_old_used", {31'd0, valid}, 32'd0);
    tick();
    check("msk15_valid", {31'd0, valid}, 32'd1);
    check("msk15_idx", {28'd0, idx}, 32'd15);
    do_ack("msk15_ack", 16'h0000);

    // Stability: new higher request while presenting 4
    pulse(16'h0010);
    tick();
    check("stb4_idx", {28'd0, idx}, 32'd4);
    pulse(16'h0200);
    check("stb_pend", {16'd0, pending}, 32'h0210);
    tick();
    check("stb4_hold_valid", {31'd0, valid}, 32'd1);
    check("stb4_hold_idx", {28'd0, idx}, 32'd4);
    do_ack("stb4_ack", 16'h0200);
    tick();
    check("stb9_idx", {28'd0, idx}, 32'd9);
    do_ack("stb9_ack", 16'h0000);

    // Rise on bit 4 coincident with its ack: set wins
    pulse(16'h0010);
    tick();
    check("col4_idx", {28'd0, idx}, 32'd4);
    req = 16'h0010;
    do_ack("col4_ack", 16'h0010);
    req = 16'h0000;
    tick();
    check("col4_re_valid", {31'd0, valid}, 32'd1);
    check("col4_re_idx", {28'd0, idx}, 32'd4);
    do_ack("col4_re_ack", 16'h0000);

    // Ack while idle must not clear a masked pending bit
    load_mask(16'h0000);
    pulse(16'h0080);
    tick();
    check("idle_pend_before", {16'd0, pending}, 32'h0080);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("idle_ack_valid", {31'd0, valid}, 32'd0);
    check("idle_ack_pend", {16'd0, pending}, 32'h0080);
    load_mask(16'hFFFF);
    tick();
    check("idle7_idx", {28'd0, idx}, 32'd7);
    do_ack("idle7_ack", 16'h0000);

    // Reset mid-operation with pending 0081 and valid high
    pulse(16'h0081);
    tick();
    check("mid_valid", {31'd0, valid}, 32'd1);
    check("mid_idx", {28'd0, idx}, 32'd7);
    load_mask(16'h0001);
    req = 16'h0040;
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, valid}, 32'd0);
    check("mid_rst_idx", {28'd0, idx}, 32'd0);
    check("mid_rst_pend", {16'd0, pending}, 32'h0000);
    tick();
    reset = 1'b0;
    // req[6] held through reset pends on the first edge after release
    tick();
    check("held6_pend", {16'd0, pending}, 32'h0040);
    req = 16'h0000;
    tick();
    check("held6_valid", {31'd0, valid}, 32'd1);
    check("held6_idx", {28'd0, idx}, 32'd6);
    do_ack("held6_ack", 16'h0000);

    // Exhaustive single-source sweep
    for (int i = 0; i < 16; i++) begin
      logic [15:0] bitv;
      bitv = 16'h0001 << i;
      pulse(bitv);
      tick();
      check($sformatf("sweep%0d_valid", i), {31'd0, valid}, 32'd1);
      check($sformatf("sweep%0d_idx", i), {28'd0, idx}, i);
      do_ack($sformatf("sweep%0d_ack", i), 16'h0000);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/irq_encoder16_4.md
# irq_encoder16_4

Sequential 16:4 priority encoder with pending latch, mask and acknowledge handshake: the encode-side counterpart of the 4:16 select decoder. It collects up to 16 request lines from peripherals or exception sources and presents the highest-priority unmasked pending source to the CPU control path as a 4-bit index. It holds that index stable until the consumer acknowledges it.

## Interface
- No parameters; width fixed at 16 sources / 4-bit index.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  16  level request lines; a 0→1 transition makes the source pending.
- mask_we  input  1  when 1, mask register loads mask_in at the clock edge.
- mask_in  input  16  new mask value; bit = 1 enables that source.
- ack  input  1  consumer accepts the presented index; honoured only while valid = 1.
- valid  output  1  idx holds an accepted, stable source number.
- idx  output  4  source number being presented.
- pending  output  16  current pending register, unmasked view.

## Operation
- Edge detect:
  - req_q registers req each cycle.
  - rise = req & ~req_q.
  - A pending bit sets at the edge where its rise bit = 1.
  - Level-high req without a new edge does not re-pend.
- Mask:
  - Register, reset 16'hFFFF.
  - Loaded on mask_we.
  - Masks only selection; pending bits still accumulate while masked.
- Priority: among pending & mask, the highest index wins (bit 15 highest, bit 0 lowest).
- FSM, two states:
  - IDLE: valid = 0. If (pending & mask) != 0, latch the winning index into idx and go to PRESENT.
  - PRESENT: valid = 1; idx frozen; pending/mask changes do not alter idx or drop valid. On ack, clear pending[idx] and go to IDLE.
  - ack in IDLE is ignored.
- Simultaneous events:
  - rise on bit idx in the same cycle as ack: set wins; the bit stays pending and can be re-presented.
  - rise on other bits in any state: sets normally.
  - mask_we in the same cycle as the IDLE→PRESENT decision: selection uses the old mask value.
  - A masked-off source already being presented stays presented until ack.
- Reset mid-operation:
  - All state clears immediately.
  - An in-flight presentation is lost.
  - Sources still held high after reset are re-detected as new rises only if req_q had cleared; req_q resets to 0, so held-high lines pend on the first edge after reset.

## Timing
- Reset values:
  - valid = 0, idx = 4'd0, pending = 16'h0000.
  - mask = 16'hFFFF, req_q = 0, state IDLE.
- Request latency:
  - req high during cycle k sets pending at edge k.
  - valid = 1 with idx from edge k+1.
  - Two edges from request to valid.
- Handshake:
  - ack sampled high at edge m while valid → valid = 0 and pending[idx] = 0 after edge m.
  - If other unmasked sources are pending, valid re-asserts after edge m+1.
  - Minimum one-cycle valid-low gap between presentations.
- idx holds its last value while valid = 0; consumers qualify it with valid.
- Fully synchronous apart from reset; no combinational path from req, ack or mask_in to valid or idx.

## Test plan
- Reset: assert reset mid-cycle with pending = 16'h0081 and valid = 1 → all outputs return to reset values immediately; mask reads back as 16'hFFFF behaviour.
- Single source: pulse req[5] for one cycle → pending = 16'h0020, then valid = 1 and idx = 5 two edges after request. Ack → valid = 0 and pending = 0 the next cycle.
- Priority and ordering:
  - Raise req[3], req[12] and req[0] on the same edge; ack each presentation.
  - Required sequence: idx = 12, 3, 0, each separated by one valid-low cycle; pending ends at 0.
- Mask:
  - Load mask 16'h7FFF, then pulse req[15] and req[2] → idx = 2 only; pending keeps bit 15.
  - Load mask 16'hFFFF after acking 2 → idx = 15 presented.
- Stability and collisions:
  - While presenting idx = 4, pulse req[9] → idx stays 4 until ack, then 9 is presented.
  - rise on req[4] in the same cycle as its ack → bit 4 re-presented.
  - ack while valid = 0 → no state change.
- Exhaustive single-source sweep: for i = 0..15 pulse req[i] alone, ack, and check idx == i → 16 passes, no mismatches.
